// File: rtl/mem_bus_ctrl.sv
// -----------------------------------------------------------------------------
// mem_bus_ctrl
// Puts the loads and stores issued by the MEM stage onto the single-master
// data bus. Data memory is big-endian: byte offset 0 is bits 31:24.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   mem_req_i         MEM stage holds a load/store this cycle
//   mem_we_i          1 = store, 0 = load
//   mem_size_i        00 byte, 01 half, 10/11 word
//   mem_signed_i      sign-extend a byte/half load
//   mem_addr_i        byte address
//   mem_wdata_i       right-justified store data
//   flush_i           kill the instruction currently in MEM
//   bus_ack_i         bus transfer complete
//   bus_rdata_i       bus read data, valid with bus_ack_i
//   bus_ce_o          bus request
//   bus_we_o          bus write enable
//   bus_addr_o        word-aligned bus address
//   bus_sel_o         byte-lane enables
//   bus_wdata_o       lane-replicated store data
//   stall_req_o       stall request to the pipeline controller
//   rdata_o           extended load result (held until next capture)
//   rdata_valid_o     one-cycle load-complete strobe
//   misalign_o        misaligned access detected
//   bus_err_o         one-cycle bus timeout strobe
// -----------------------------------------------------------------------------
module mem_bus_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [1:0]  mem_size_i,
    input  logic        mem_signed_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic        flush_i,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i,
    output logic        bus_ce_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_wdata_o,
    output logic        stall_req_o,
    output logic [31:0] rdata_o,
    output logic        rdata_valid_o,
    output logic        misalign_o,
    output logic        bus_err_o
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        kill_q, kill_d;
    logic        err_q, err_d;
    logic        we_q, we_d;
    logic        signed_q, signed_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;

    logic        misaligned;
    logic        accept;
    logic        timeout_hit;
    logic [3:0]  sel_in;
    logic [31:0] wdata_in;
    logic [31:0] load_ext;
    logic [31:0] byte_shifted;
    logic [15:0] half_lane;

    assign misaligned  = ((mem_size_i == 2'b01) & mem_addr_i[0])
                       | (mem_size_i[1] & (|mem_addr_i[1:0]));
    assign accept      = (state_q == S_IDLE) & mem_req_i & ~flush_i & ~misaligned;
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Lane selects and store-data replication for the incoming request
    always_comb begin
        sel_in   = 4'b1111;
        wdata_in = mem_wdata_i;
        case (mem_size_i)
            2'b00: begin
                sel_in   = 4'b1000 >> mem_addr_i[1:0];
                wdata_in = {4{mem_wdata_i[7:0]}};
            end
            2'b01: begin
                sel_in   = mem_addr_i[1] ? 4'b0011 : 4'b1100;
                wdata_in = {2{mem_wdata_i[15:0]}};
            end
            default: begin
                sel_in   = 4'b1111;
                wdata_in = mem_wdata_i;
            end
        endcase
    end

    // Big-endian lane extraction: offset 0 lives in the top byte, so the
    // byte is shifted down by (3 - offset) bytes.
    assign byte_shifted = bus_rdata_i >> {~addr_q[1:0], 3'b000};
    assign half_lane    = addr_q[1] ? bus_rdata_i[15:0] : bus_rdata_i[31:16];

    always_comb begin
        load_ext = bus_rdata_i;
        case (size_q)
            2'b00:   load_ext = {{24{signed_q & byte_shifted[7]}}, byte_shifted[7:0]};
            2'b01:   load_ext = {{16{signed_q & half_lane[15]}}, half_lane};
            default: load_ext = bus_rdata_i;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        kill_d   = kill_q;
        err_d    = err_q;
        we_d     = we_q;
        signed_d = signed_q;
        size_d   = size_q;
        addr_d   = addr_q;
        sel_d    = sel_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        case (state_q)
            S_IDLE: begin
                kill_d = 1'b0;
                err_d  = 1'b0;
                if (accept) begin
                    we_d     = mem_we_i;
                    signed_d = mem_signed_i;
                    size_d   = mem_size_i;
                    addr_d   = mem_addr_i;
                    sel_d    = sel_in;
                    wdata_d  = wdata_in;
                    cnt_d    = '0;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                // The bus cannot cancel, so a flush only marks the access dead.
                if (flush_i) begin
                    kill_d = 1'b1;
                end
                if (bus_ack_i) begin
                    rdata_d = load_ext;
                    state_d = kill_q ? S_IDLE : S_DONE;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                kill_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            kill_q   <= 1'b0;
            err_q    <= 1'b0;
            we_q     <= 1'b0;
            signed_q <= 1'b0;
            size_q   <= 2'b00;
            addr_q   <= '0;
            sel_q    <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            kill_q   <= kill_d;
            err_q    <= err_d;
            we_q     <= we_d;
            signed_q <= signed_d;
            size_q   <= size_d;
            addr_q   <= addr_d;
            sel_q    <= sel_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
        end
    end

    // Outputs: everything is forced low while reset is held.
    logic in_wait;
    logic done_live;

    assign in_wait   = ~rst & (state_q == S_WAIT);
    // A flush arriving in DONE or a kill flag from WAIT suppresses both strobes
    assign done_live = ~rst & (state_q == S_DONE) & ~kill_q & ~flush_i;

    assign bus_ce_o      = in_wait;
    assign bus_we_o      = in_wait & we_q;
    assign bus_addr_o    = in_wait ? {addr_q[31:2], 2'b00} : 32'h0;
    assign bus_sel_o     = in_wait ? sel_q : 4'h0;
    assign bus_wdata_o   = in_wait ? wdata_q : 32'h0;
    assign stall_req_o   = ~rst & (accept | (state_q == S_WAIT));
    assign rdata_o       = rst ? 32'h0 : rdata_q;
    assign rdata_valid_o = done_live & ~we_q & ~err_q;
    assign bus_err_o     = done_live & err_q;
    assign misalign_o    = ~rst & (state_q == S_IDLE) & mem_req_i & ~flush_i & misaligned;

endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
- Sequences data-memory loads and stores issued by the MEM stage onto the single-master data bus.
- Generates lane selects and store-data replication, handles the request/ack handshake, and stalls the pipeline while a transfer is in flight.
- Returns aligned and extended load data to the MEM stage.
- Flags misaligned accesses and bus timeouts.
- Data memory is big-endian: byte address offset 0 maps to bits 31:24.

Parameters:
- TIMEOUT_CYCLES, default 255: number of WAIT cycles without bus_ack_i before the access is aborted with bus_err_o.
- CNT_W, default 8: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high (`RstEnable).
- mem_req_i  in  1  MEM stage holds a load/store this cycle.
- mem_we_i  in  1  1 = store, 0 = load.
- mem_size_i  in  2  00 = byte, 01 = half, 10 = word; 11 is treated as word.
- mem_signed_i  in  1  sign-extend a byte/half load.
- mem_addr_i  in  32  byte address.
- mem_wdata_i  in  32  store data, right-justified.
- flush_i  in  1  kill the instruction currently in MEM.
- bus_ack_i  in  1  bus transfer complete.
- bus_rdata_i  in  32  bus read data, valid with bus_ack_i.
- bus_ce_o  out  1  bus request.
- bus_we_o  out  1  bus write enable.
- bus_addr_o  out  32  word-aligned address ({addr[31:2], 2'b00}).
- bus_sel_o  out  4  byte-lane enables.
- bus_wdata_o  out  32  lane-replicated store data.
- stall_req_o  out  1  stall request to the pipeline controller.
- rdata_o  out  32  extended load result.
- rdata_valid_o  out  1  one-cycle load-complete strobe.
- misalign_o  out  1  misaligned access detected.
- bus_err_o  out  1  one-cycle timeout strobe.

Behaviour:
- Reset:
  - While rst=1, every output is forced to 0 combinationally.
  - On the rising edge with rst=1: state <= IDLE; timeout counter, kill flag and all captured registers clear.
- Reset mid-transfer: bus_ce_o drops in the reset cycle. No completion strobe is produced.
- Misalignment: misaligned = (size=01 & addr[0]) | (size=10/11 & addr[1:0]!=0).
- Lane selects:
  - Byte: sel = 1000 >> addr[1:0].
  - Half: addr[1]=0 -> 1100, addr[1]=1 -> 0011.
  - Word: 1111.
- Store data replication: byte = {4{wdata[7:0]}}, half = {2{wdata[15:0]}}, word unchanged.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - Accept condition: mem_req_i & !flush_i & !misaligned.
  - On accept: stall_req_o=1 (combinational, same cycle); capture we/addr/sel/wdata/size/signed; next state WAIT; counter <= 0.
  - mem_req_i & misaligned & !flush_i: misalign_o=1 the same cycle, no stall, no bus access, stay IDLE.
  - bus_ce_o=0 in IDLE.
- WAIT:
  - bus_ce_o=1 and stall_req_o=1. bus_* outputs are driven from the captured registers and are stable for the whole state.
  - Counter increments each cycle without ack.
  - bus_ack_i=1: capture the extended load data; next state DONE, or IDLE if the kill flag is set. bus_ack_i has priority over timeout in the same cycle.
  - counter == TIMEOUT_CYCLES-1 with no ack: next state DONE with an error flag; rdata is captured as 0.
  - flush_i in WAIT sets the kill flag. The transfer is not aborted (the bus cannot cancel); stall_req_o stays 1 until ack or timeout.
- DONE:
  - stall_req_o=0 and bus_ce_o=0.
  - rdata_valid_o=1 for one cycle if the access was a load and not killed.
  - bus_err_o=1 for one cycle if timed out and not killed.
  - flush_i in DONE suppresses both strobes.
  - mem_req_i is ignored (it belongs to the same instruction, which advances at the end of this cycle).
  - Next state is always IDLE.
- Load extension:
  - Lane is chosen by the captured addr[1:0], big-endian.
  - Byte/half are zero- or sign-extended per mem_signed_i.
  - Word passes through.
- Stores never assert rdata_valid_o.
- rdata_o holds its value until the next capture.
- Latency: minimum 3 cycles from accept to DONE (IDLE, WAIT with ack, DONE). The pipeline is stalled for 2 of these cycles.

Test Plan:
- Word load, addr 0x100, ack on the 2nd WAIT cycle with bus_rdata 0xDEADBEEF -> sel=1111, bus_addr=0x100, stall high 3 cycles, then rdata_o=0xDEADBEEF with rdata_valid_o high 1 cycle.
- Signed byte load, addr 0x103, bus_rdata 0x11223380 -> sel=0001, rdata_o=0xFFFFFF80. Same access unsigned -> 0x00000080.
- Half store, addr 0x202, wdata 0x0000ABCD -> bus_we=1, sel=0011, bus_wdata=0xABCDABCD, bus_addr=0x200. No rdata_valid_o.
- Word load at 0x101 -> misalign_o=1 in the same cycle, bus_ce_o stays 0, stall_req_o stays 0.
- TIMEOUT_CYCLES=4, no ack -> bus_ce_o high exactly 4 cycles, then bus_err_o pulses once, rdata_o=0, FSM returns to IDLE.
- flush_i pulsed in WAIT, ack 3 cycles later -> bus_ce_o held until ack, stall_req_o high through the ack cycle, then returns to IDLE with no rdata_valid_o or bus_err_o. Separately, rst asserted in WAIT -> all outputs 0 the same cycle and state IDLE after the edge.
